// File: rtl/rv32i_pkg.sv
// Shared core package: RAM base address and memory port owner tags.
// Imported by the memory port arbiter and its starve guard.
package rv32i_pkg;

  localparam logic [31:0] RAM_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D_RD,
    OWN_D_WR
  } mem_owner_e;

endpackage

// File: rtl/mem_starve_guard.sv
// Counts consecutive denied fetch cycles and forces fetch through at limit.
// Ports: clk, reset_n, i_if_req, i_if_gnt in; o_force_if out.
module mem_starve_guard
  import rv32i_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_force_if
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_force_if = (r_cnt == LIMIT) & i_if_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync-read RAM between fetch (IF) and load/store (D) ports.
// Ports: if_* fetch, d_* data, mem_* RAM side; clk, reset_n (async, low).
// Option: MEM_PORT_ARBITER_STARVE_GUARD_EN adds the fetch starve guard.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int          ADDR_W       = 14,
  parameter logic [31:0] BASE_ADDR    = RAM_BASE_ADDR,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic              w_force_if;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic [31:0]       w_addr;
  logic [ADDR_W-1:0] w_word;
  mem_owner_e        r_own;
  mem_owner_e        w_own_nxt;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
  mem_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_guard (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_if_req  (if_req),
    .i_if_gnt  (w_if_gnt),
    .o_force_if(w_force_if)
  );
`else
  logic w_unused_limit;
  assign w_unused_limit = |STARVE_LIMIT;
  assign w_force_if     = 1'b0;
`endif

  // Grants are masked while reset is held so every output reads 0.
  assign w_d_gnt  = reset_n & d_req & ~w_force_if;
  assign w_if_gnt = reset_n & if_req & (~d_req | w_force_if);
  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;

  // Out-of-window addresses wrap modulo RAM depth by truncation.
  assign w_addr = w_d_gnt ? d_addr : if_addr;
  assign w_word = ADDR_W'((w_addr - BASE_ADDR) >> 2);

  assign mem_en    = w_if_gnt | w_d_gnt;
  assign mem_addr  = mem_en ? w_word : '0;
  assign mem_we    = (w_d_gnt & d_we) ? d_be : 4'b0;
  assign mem_wdata = reset_n ? d_wdata : 32'h0;

  always_comb begin
    w_own_nxt = OWN_NONE;
    unique case (1'b1)
      w_d_gnt & d_we:  w_own_nxt = OWN_D_WR;
      w_d_gnt & ~d_we: w_own_nxt = OWN_D_RD;
      w_if_gnt:        w_own_nxt = OWN_IF;
      default:         w_own_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_own <= OWN_NONE;
    end else begin
      r_own <= w_own_nxt;
    end
  end

  assign if_rvalid = (r_own == OWN_IF);
  assign d_rvalid  = (r_own == OWN_D_RD) | (r_own == OWN_D_WR);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = (r_own == OWN_D_RD) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural RAM.
// RAM word i is preloaded with 32'h1000_0000 + i.
module tb_mem_port_arbiter;

  localparam int AW = 14;

  logic          clk;
  logic          reset_n;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] ram [2**AW];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ifg"}, {31'b0, if_gnt}, 0);
    chk({tag, "_ifv"}, {31'b0, if_rvalid}, 0);
    chk({tag, "_ifd"}, if_rdata, 0);
    chk({tag, "_dg"}, {31'b0, d_gnt}, 0);
    chk({tag, "_dv"}, {31'b0, d_rvalid}, 0);
    chk({tag, "_dd"}, d_rdata, 0);
    chk({tag, "_men"}, {31'b0, mem_en}, 0);
    chk({tag, "_mwe"}, {28'b0, mem_we}, 0);
    chk({tag, "_mad"}, 32'(mem_addr), 0);
    chk({tag, "_mwd"}, mem_wdata, 0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = 32'h1000_0000 + i;
    mem_rdata = 0;
    reset_n = 0;
    idle_all();
    repeat (2) nxt();
    d_req = 1; d_we = 1; d_be = 4'hf; d_wdata = 32'h1234_5678; if_req = 1;
    settle();
    chk_all_zero("rst");
    idle_all();

    nxt(); reset_n = 1;

    nxt(); if_req = 1; if_addr = 32'h8000_0010; settle();
    chk("if_gnt", {31'b0, if_gnt}, 1);
    chk("if_dg", {31'b0, d_gnt}, 0);
    chk("if_men", {31'b0, mem_en}, 1);
    chk("if_mad", 32'(mem_addr), 4);
    chk("if_mwe", {28'b0, mem_we}, 0);
    chk("if_v0", {31'b0, if_rvalid}, 0);
    nxt(); idle_all(); settle();
    chk("if_v1", {31'b0, if_rvalid}, 1);
    chk("if_d1", if_rdata, 32'h1000_0004);
    chk("if_dv1", {31'b0, d_rvalid}, 0);
    chk("if_men1", {31'b0, mem_en}, 0);
    nxt(); settle();
    chk("if_v2", {31'b0, if_rvalid}, 0);
    chk("if_d2", if_rdata, 0);

    nxt(); d_req = 1; d_we = 1; d_be = 4'b0011;
    d_addr = 32'h8000_0020; d_wdata = 32'hDEAD_BEEF; settle();
    chk("st_gnt", {31'b0, d_gnt}, 1);
    chk("st_mwe", {28'b0, mem_we}, 4'b0011);
    chk("st_mad", 32'(mem_addr), 8);
    chk("st_mwd", mem_wdata, 32'hDEAD_BEEF);
    nxt(); d_we = 0; d_be = 0; d_wdata = 0; settle();
    chk("st_ack", {31'b0, d_rvalid}, 1);
    chk("st_ackd", d_rdata, 0);
    chk("ld_gnt", {31'b0, d_gnt}, 1);
    chk("ld_mwe", {28'b0, mem_we}, 0);
    nxt(); idle_all(); settle();
    chk("ld_v", {31'b0, d_rvalid}, 1);
    chk("ld_d", d_rdata, 32'h1000_BEEF);

    nxt(); if_req = 1; if_addr = 32'h8000_0000;
    for (int k = 0; k < 3; k++) begin
      d_req = 1; d_addr = 32'h8000_0004 + 32'(4 * k); settle();
      chk("cn_dg", {31'b0, d_gnt}, 1);
      chk("cn_ifg", {31'b0, if_gnt}, 0);
      if (k > 0) begin
        chk("cn_dv", {31'b0, d_rvalid}, 1);
        chk("cn_dd", d_rdata, 32'h1000_0000 + 32'(k));
      end
      nxt();
    end
    d_req = 0; d_addr = 0; settle();
    chk("cn_ifg2", {31'b0, if_gnt}, 1);
    chk("cn_mad2", 32'(mem_addr), 0);
    chk("cn_dv3", {31'b0, d_rvalid}, 1);
    chk("cn_dd3", d_rdata, 32'h1000_0003);
    nxt(); idle_all(); settle();
    chk("cn_ifv", {31'b0, if_rvalid}, 1);
    chk("cn_ifd", if_rdata, 32'h1000_0000);
    chk("cn_dv4", {31'b0, d_rvalid}, 0);

    nxt(); if_req = 1; if_addr = 32'h8000_0040; settle();
    chk("al_ifg", {31'b0, if_gnt}, 1);
    nxt(); idle_all(); d_req = 1; d_addr = 32'h8000_0044; settle();
    chk("al_dg", {31'b0, d_gnt}, 1);
    chk("al_ifv", {31'b0, if_rvalid}, 1);
    chk("al_ifd", if_rdata, 32'h1000_0010);
    chk("al_dv0", {31'b0, d_rvalid}, 0);
    nxt(); idle_all(); if_req = 1; if_addr = 32'h8000_0048; settle();
    chk("al_ifg2", {31'b0, if_gnt}, 1);
    chk("al_dv", {31'b0, d_rvalid}, 1);
    chk("al_dd", d_rdata, 32'h1000_0011);
    chk("al_ifv0", {31'b0, if_rvalid}, 0);
    chk("al_ifd0", if_rdata, 0);
    nxt(); idle_all(); settle();
    chk("al_ifv2", {31'b0, if_rvalid}, 1);
    chk("al_ifd2", if_rdata, 32'h1000_0012);
    chk("al_dv2", {31'b0, d_rvalid}, 0);

    nxt(); d_req = 1; d_addr = 32'h0000_0013; settle();
    chk("wr_mad", 32'(mem_addr), 4);
    nxt(); idle_all(); settle();
    chk("wr_dd", d_rdata, 32'h1000_0004);

    nxt(); d_req = 1; d_addr = 32'h8000_0008; settle();
    chk("rs_dg", {31'b0, d_gnt}, 1);
    nxt(); idle_all(); reset_n = 0; settle();
    chk_all_zero("rsm");
    nxt(); reset_n = 1;
    for (int k = 0; k < 2; k++) begin
      nxt(); settle();
      chk("rs_dv", {31'b0, d_rvalid}, 0);
      chk("rs_dd", d_rdata, 0);
    end

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    nxt(); if_req = 1; if_addr = 32'h8000_0000;
    d_req = 1; d_addr = 32'h8000_0004;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("sv_dg", {31'b0, d_gnt}, 1);
      chk("sv_ifg", {31'b0, if_gnt}, 0);
      nxt();
    end
    settle();
    chk("sv_ifg5", {31'b0, if_gnt}, 1);
    chk("sv_dg5", {31'b0, d_gnt}, 0);
    nxt(); if_req = 0; settle();
    chk("sv_ifv", {31'b0, if_rvalid}, 1);
    chk("sv_ifd", if_rdata, 32'h1000_0000);
    chk("sv_dg6", {31'b0, d_gnt}, 1);
    nxt(); if_req = 1; settle();
    chk("sv_ifg7", {31'b0, if_gnt}, 0);
    nxt(); idle_all();
    nxt();
`endif

    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
